// File: rtl/packet_retry_tx_if.sv
// Stream bundle (valid/ready/last/data) shared by the FIFO read side and the link side.
interface packet_retry_tx_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic [WIDTH-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input  tready);
    modport slave  (input  tvalid, input  tlast, input  tdata, output tready);
endinterface

// File: rtl/packet_retry_tx.sv
// Drains a packet FIFO onto the link stream, then commits (next_o) or replays (redo_o)
// each packet on link ACK/NAK/timeout. Optional counters: PACKET_RETRY_TX_STATS_EN.
module packet_retry_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned REDO_GAP  = 2,
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    packet_retry_tx_if.slave  s,
    packet_retry_tx_if.master m,
    output logic              next_o,
    output logic              redo_o,
    input  logic              ack_i,
    input  logic              nak_i,
    output logic              busy_o,
    output logic              fail_o,
    output logic [RW-1:0]     retry_o
`ifdef PACKET_RETRY_TX_STATS_EN
    ,
    output logic [15:0]       stat_sent_o,
    output logic [15:0]       stat_retry_o,
    output logic [15:0]       stat_fail_o
`endif
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = $clog2(REDO_GAP + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, REDO} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [RW-1:0]   retry_d;
    logic            next_d, redo_d, fail_d, busy_d;
    logic            send_c;
    logic [WIDTH-1:0] data_c;

    // Zero-latency pass-through, only open while sending
    assign send_c   = (state_q == SEND);
    assign m.tvalid = s.tvalid & send_c;
    assign s.tready = m.tready & send_c;
    assign m.tlast  = s.tlast;
    assign data_c   = s.tdata;
    assign m.tdata  = data_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            gap_q   <= '0;
            retry_o <= '0;
            next_o  <= 1'b0;
            redo_o  <= 1'b0;
            fail_o  <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            retry_o <= retry_d;
            next_o  <= next_d;
            redo_o  <= redo_d;
            fail_o  <= fail_d;
            busy_o  <= busy_d;
        end
    end

    // Next-state and pulse decode; ack takes priority over nak and over timer expiry
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        retry_d = retry_o;
        next_d  = 1'b0;
        redo_d  = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s.tvalid) state_d = SEND;
            end
            SEND: begin
                if (s.tvalid && m.tready && s.tlast) begin
                    state_d = WAIT;
                    timer_d = TW'(TIMEOUT);
                end
            end
            WAIT: begin
                timer_d = timer_q - TW'(1);
                if (ack_i) begin
                    next_d  = 1'b1;
                    retry_d = '0;
                    state_d = IDLE;
                end else if (nak_i || (timer_q == TW'(1))) begin
                    if (retry_o < RW'(MAX_RETRY)) begin
                        redo_d  = 1'b1;
                        retry_d = retry_o + RW'(1);
                        gap_d   = GW'(REDO_GAP - 1);
                        state_d = REDO;
                    end else begin
                        next_d  = 1'b1;
                        fail_d  = 1'b1;
                        retry_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            REDO: begin
                if (gap_q == '0) state_d = SEND;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef PACKET_RETRY_TX_STATS_EN
    // Event counters driven from the registered pulses, wrapping naturally
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_sent_o  <= '0;
            stat_retry_o <= '0;
            stat_fail_o  <= '0;
        end else begin
            if (next_o && !fail_o) stat_sent_o  <= stat_sent_o + 16'd1;
            if (redo_o)            stat_retry_o <= stat_retry_o + 16'd1;
            if (fail_o)            stat_fail_o  <= stat_fail_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_packet_retry_tx.sv
// Randomized self-checking bench for packet_retry_tx against a packet-level reference model.
module tb_packet_retry_tx;
    localparam int unsigned W = 8, TO = 15, MR = 3, RG = 2;
    localparam int K_ACK = 0, K_NAK = 1, K_NONE = 2, K_BOTH = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ack_i = 1'b0, nak_i = 1'b0;
    logic       next_o, redo_o, fail_o, busy_o;
    logic [1:0] retry_o;
`ifdef PACKET_RETRY_TX_STATS_EN
    logic [15:0] stat_sent_o, stat_retry_o, stat_fail_o;
`endif

    packet_retry_tx_if #(.WIDTH(W)) s_if ();
    packet_retry_tx_if #(.WIDTH(W)) m_if ();

    packet_retry_tx #(.WIDTH(W), .TIMEOUT(TO), .MAX_RETRY(MR), .REDO_GAP(RG)) dut (
        .clock(clock), .reset_n(reset_n), .s(s_if), .m(m_if),
        .next_o(next_o), .redo_o(redo_o), .ack_i(ack_i), .nak_i(nak_i),
        .busy_o(busy_o), .fail_o(fail_o), .retry_o(retry_o)
`ifdef PACKET_RETRY_TX_STATS_EN
        , .stat_sent_o(stat_sent_o), .stat_retry_o(stat_retry_o), .stat_fail_o(stat_fail_o)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0;
    int exp_sent = 0, exp_retry = 0, exp_fail = 0;

    logic [7:0] pkt_q[$];
    int         kind_q[$], dly_q[$];

    logic [7:0] ob_data[$];
    bit         ob_last[$];
    int         ob_retry[$], ob_cyc[$], ob_lastc[$];
    int         ob_next[$], ob_redo[$], ob_fail[$];
    int         ob_both, ob_mirror, ob_hung;

    function automatic int kind_at(input int a);
        return (a < kind_q.size()) ? kind_q[a] : K_NONE;
    endfunction

    // Cycles from the last-beat cycle to the visible commit/replay pulse for attempt a
    function automatic int pulse_off(input int a);
        return (kind_at(a) == K_NONE) ? int'(TO) + 1 : dly_q[a] + 1;
    endfunction

    // Packet-level outcome: attempts made, replays issued, dropped or not
    function automatic void ref_outcome(output int att, output int redos, output bit failed);
        int k;
        for (int a = 0; a <= int'(MR); a++) begin
            k = kind_at(a);
            if (k == K_ACK || k == K_BOTH) begin
                att = a + 1; redos = a; failed = 1'b0;
                return;
            end
        end
        att = int'(MR) + 1; redos = int'(MR); failed = 1'b1;
    endfunction

    // Plays the FIFO (with replay on redo_o) and the link responder; records what it sees
    task automatic drive_packet(input int vmode, input int rmode);
        int cyc = 0, ptr = 0, att = 0, wstart = -1, k, len;
        bit done = 1'b0, xfer = 1'b0, prev_v = 1'b0, saw_redo, saw_next;
        len = pkt_q.size();
        ob_data.delete(); ob_last.delete(); ob_retry.delete(); ob_cyc.delete(); ob_lastc.delete();
        ob_next.delete(); ob_redo.delete(); ob_fail.delete();
        ob_both = 0; ob_mirror = 0; ob_hung = 0;
        while (!done) begin
            s_if.tvalid = (ptr < len) && (vmode == 0 || (prev_v && !xfer) || $urandom_range(0, 2) != 0);
            s_if.tdata  = (ptr < len) ? pkt_q[ptr] : 8'h00;
            s_if.tlast  = (ptr == len - 1);
            m_if.tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            ack_i = 1'b0; nak_i = 1'b0;
            k = kind_at(att);
            if (wstart >= 0 && k != K_NONE && cyc == wstart + dly_q[att] - 1) begin
                ack_i = (k == K_ACK || k == K_BOTH);
                nak_i = (k == K_NAK || k == K_BOTH);
            end
            prev_v = s_if.tvalid;
            @(negedge clock);
            xfer = s_if.tvalid && s_if.tready;
            if (m_if.tvalid && m_if.tready) begin
                ob_data.push_back(m_if.tdata); ob_last.push_back(m_if.tlast);
                ob_retry.push_back(int'(retry_o)); ob_cyc.push_back(cyc);
                if (m_if.tlast) ob_lastc.push_back(cyc);
            end
            if (m_if.tvalid && (s_if.tready !== m_if.tready)) ob_mirror++;
            saw_next = next_o; saw_redo = redo_o;
            if (next_o) ob_next.push_back(cyc);
            if (redo_o) ob_redo.push_back(cyc);
            if (fail_o) ob_fail.push_back(cyc);
            if (next_o && redo_o) ob_both++;
            @(posedge clock); #1;
            cyc++;
            if (xfer) begin
                if (ptr == len - 1) wstart = cyc;
                ptr++;
            end
            if (saw_redo) begin ptr = 0; att++; wstart = -1; end
            if (saw_next) done = 1'b1;
            if (cyc > 3000) begin ob_hung = 1; done = 1'b1; end
        end
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; ack_i = 1'b0; nak_i = 1'b0; m_if.tready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; m_if.tready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if ({next_o, redo_o, fail_o} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {next_o, redo_o, fail_o}); end
        checks++; if (retry_o !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_o); end
        checks++; if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_stream: s_tready=%b m_tvalid=%b want 0 0", s_if.tready, m_if.tvalid); end
`ifdef PACKET_RETRY_TX_STATS_EN
        checks++; if ({stat_sent_o, stat_retry_o, stat_fail_o} !== 48'd0) begin errors++; $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0", stat_sent_o, stat_retry_o, stat_fail_o); end
`endif
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_ack();
        pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44}; kind_q = '{K_ACK}; dly_q = '{5};
        drive_packet(0, 0);
        checks++; if (ob_hung !== 0) begin errors++; $display("FAIL ack_hung: got %0d want 0", ob_hung); end
        checks++; if (ob_data.size() !== 4) begin errors++; $display("FAIL ack_beats: got %0d want 4", ob_data.size()); end
        for (int i = 0; i < ob_data.size() && i < 4; i++) begin
            checks++;
            if (ob_data[i] !== pkt_q[i] || ob_last[i] !== (i == 3) || ob_retry[i] !== 0) begin
                errors++; $display("FAIL ack_beat%0d: got %h/%b/%0d want %h/%b/0", i, ob_data[i], ob_last[i], ob_retry[i], pkt_q[i], i == 3);
            end
        end
        checks++; if (ob_next.size() !== 1 || ob_next[0] !== ob_lastc[0] + pulse_off(0)) begin errors++; $display("FAIL ack_next: got n=%0d at %0d want 1 at %0d", ob_next.size(), ob_next[0], ob_lastc[0] + pulse_off(0)); end
        checks++; if (ob_redo.size() !== 0 || ob_fail.size() !== 0) begin errors++; $display("FAIL ack_extra: got redo=%0d fail=%0d want 0 0", ob_redo.size(), ob_fail.size()); end
        checks++; if (busy_o !== 1'b0 || retry_o !== 2'd0) begin errors++; $display("FAIL ack_idle: got busy=%b retry=%0d want 0 0", busy_o, retry_o); end
        exp_sent++;
    endtask

    task automatic test_nak_then_ack();
        pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44}; kind_q = '{K_NAK, K_ACK}; dly_q = '{3, 2};
        drive_packet(0, 0);
        checks++; if (ob_data.size() !== 8) begin errors++; $display("FAIL nak_beats: got %0d want 8", ob_data.size()); end
        for (int i = 0; i < ob_data.size() && i < 8; i++) begin
            checks++;
            if (ob_data[i] !== pkt_q[i % 4] || ob_retry[i] !== i / 4) begin
                errors++; $display("FAIL nak_beat%0d: got %h retry=%0d want %h retry=%0d", i, ob_data[i], ob_retry[i], pkt_q[i % 4], i / 4);
            end
        end
        checks++; if (ob_redo.size() !== 1 || ob_redo[0] !== ob_lastc[0] + pulse_off(0)) begin errors++; $display("FAIL nak_redo: got n=%0d at %0d want 1 at %0d", ob_redo.size(), ob_redo[0], ob_lastc[0] + pulse_off(0)); end
        checks++; if (ob_cyc[4] !== ob_redo[0] + int'(RG)) begin errors++; $display("FAIL nak_gap: got resend at %0d want %0d", ob_cyc[4], ob_redo[0] + int'(RG)); end
        checks++; if (ob_next.size() !== 1 || ob_next[0] !== ob_lastc[1] + pulse_off(1) || ob_fail.size() !== 0) begin errors++; $display("FAIL nak_next: got n=%0d at %0d fail=%0d want 1 at %0d fail=0", ob_next.size(), ob_next[0], ob_fail.size(), ob_lastc[1] + pulse_off(1)); end
        checks++; if (retry_o !== 2'd0) begin errors++; $display("FAIL nak_retry_clr: got %0d want 0", retry_o); end
        exp_sent++; exp_retry++;
    endtask

    task automatic test_timeout_fail();
        pkt_q.delete();
        repeat (3) pkt_q.push_back(8'($urandom));
        kind_q.delete(); dly_q.delete();
        drive_packet(0, 0);
        checks++; if (ob_redo.size() !== 3) begin errors++; $display("FAIL to_redos: got %0d want 3", ob_redo.size()); end
        for (int a = 0; a < 3 && a < ob_redo.size(); a++) begin
            checks++; if (ob_redo[a] !== ob_lastc[a] + int'(TO) + 1) begin errors++; $display("FAIL to_redo%0d: got %0d want %0d", a, ob_redo[a], ob_lastc[a] + int'(TO) + 1); end
        end
        checks++; if (ob_next.size() !== 1 || ob_fail.size() !== 1 || ob_fail[0] !== ob_next[0]) begin errors++; $display("FAIL to_fail: got next=%0d fail=%0d want 1 1 together", ob_next.size(), ob_fail.size()); end
        checks++; if (ob_next[0] !== ob_lastc[3] + int'(TO) + 1) begin errors++; $display("FAIL to_fail_time: got %0d want %0d", ob_next[0], ob_lastc[3] + int'(TO) + 1); end
        checks++; if (ob_data.size() !== 12 || ob_retry[11] !== 3) begin errors++; $display("FAIL to_beats: got %0d retry=%0d want 12 retry=3", ob_data.size(), ob_retry[11]); end
        checks++; if (retry_o !== 2'd0) begin errors++; $display("FAIL to_retry_clr: got %0d want 0", retry_o); end
        exp_retry += 3; exp_fail++;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        pkt_q.delete();
        repeat (6) pkt_q.push_back(8'($urandom));
        kind_q = '{K_ACK}; dly_q = '{1};
        drive_packet(0, 1);
        checks++; if (ob_data.size() !== 6) begin errors++; $display("FAIL bp_beats: got %0d want 6", ob_data.size()); end
        for (int i = 0; i < ob_data.size() && i < 6; i++) if (ob_data[i] !== pkt_q[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_data: got %0d wrong beats want 0", bad); end
        checks++; if (ob_mirror !== 0) begin errors++; $display("FAIL bp_mirror: got %0d mismatches want 0", ob_mirror); end
        checks++; if (ob_next.size() !== 1 || ob_next[0] !== ob_lastc[0] + pulse_off(0)) begin errors++; $display("FAIL bp_next: got n=%0d at %0d want 1 at %0d", ob_next.size(), ob_next[0], ob_lastc[0] + pulse_off(0)); end
        exp_sent++;
    endtask

    task automatic test_simultaneous();
        pkt_q = '{8'hA5, 8'h5A}; kind_q = '{K_BOTH}; dly_q = '{4};
        drive_packet(0, 0);
        checks++; if (ob_next.size() !== 1 || ob_redo.size() !== 0 || ob_fail.size() !== 0) begin errors++; $display("FAIL both_resp: got next=%0d redo=%0d fail=%0d want 1 0 0", ob_next.size(), ob_redo.size(), ob_fail.size()); end
        kind_q = '{K_ACK}; dly_q = '{int'(TO)};
        drive_packet(0, 0);
        checks++; if (ob_next.size() !== 1 || ob_redo.size() !== 0 || ob_next[0] !== ob_lastc[0] + int'(TO) + 1) begin errors++; $display("FAIL ack_at_timeout: got next=%0d redo=%0d at %0d want 1 0 at %0d", ob_next.size(), ob_redo.size(), ob_next[0], ob_lastc[0] + int'(TO) + 1); end
        exp_sent += 2;
    endtask

    task automatic test_stray_ack();
        int pulses = 0, busy_seen = 0;
        for (int c = 0; c < 8; c++) begin
            ack_i = (c < 3); nak_i = (c == 1);
            @(negedge clock);
            if (next_o || redo_o || fail_o) pulses++;
            if (busy_o) busy_seen++;
            @(posedge clock); #1;
        end
        ack_i = 1'b0; nak_i = 1'b0;
        checks++; if (pulses !== 0 || busy_seen !== 0) begin errors++; $display("FAIL stray_ack: got pulses=%0d busy=%0d want 0 0", pulses, busy_seen); end
    endtask

    task automatic test_random();
        int att, redos, bad, len;
        bit failed;
        for (int p = 0; p < 10; p++) begin
            len = $urandom_range(1, 6);
            pkt_q.delete(); kind_q.delete(); dly_q.delete();
            repeat (len) pkt_q.push_back(8'($urandom));
            for (int a = 0; a <= int'(MR); a++) begin
                kind_q.push_back($urandom_range(0, 3));
                dly_q.push_back($urandom_range(1, TO));
            end
            ref_outcome(att, redos, failed);
            drive_packet(1, 2);
            bad = 0;
            for (int i = 0; i < ob_data.size(); i++) if (ob_data[i] !== pkt_q[i % len] || ob_last[i] !== (i % len == len - 1)) bad++;
            checks++;
            if (ob_hung !== 0 || ob_data.size() !== att * len || bad !== 0) begin
                errors++; $display("FAIL rnd%0d_beats: got %0d beats %0d bad hung=%0d want %0d beats", p, ob_data.size(), bad, ob_hung, att * len);
            end
            checks++;
            if (ob_redo.size() !== redos || ob_fail.size() !== int'(failed) || ob_next.size() !== 1 || ob_both !== 0) begin
                errors++; $display("FAIL rnd%0d_pulses: got redo=%0d fail=%0d next=%0d both=%0d want %0d %0d 1 0", p, ob_redo.size(), ob_fail.size(), ob_next.size(), ob_both, redos, failed);
            end
            exp_retry += redos;
            if (failed) exp_fail++; else exp_sent++;
        end
`ifdef PACKET_RETRY_TX_STATS_EN
        checks++;
        if (int'(stat_sent_o) !== exp_sent || int'(stat_retry_o) !== exp_retry || int'(stat_fail_o) !== exp_fail) begin
            errors++; $display("FAIL stats: got %0d/%0d/%0d want %0d/%0d/%0d", stat_sent_o, stat_retry_o, stat_fail_o, exp_sent, exp_retry, exp_fail);
        end
`endif
    endtask

    task automatic test_reset_mid();
        s_if.tvalid = 1'b1; s_if.tlast = 1'b0; s_if.tdata = 8'h77; m_if.tready = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        checks++; if (busy_o !== 1'b1 || m_if.tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre: got busy=%b m_tvalid=%b want 1 1", busy_o, m_if.tvalid); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, next_o, redo_o, fail_o, m_if.tvalid, s_if.tready} !== 6'b0 || retry_o !== 2'd0) begin
            errors++; $display("FAIL mid_reset: got busy=%b pulses=%b m_tvalid=%b s_tready=%b retry=%0d want all 0", busy_o, {next_o, redo_o, fail_o}, m_if.tvalid, s_if.tready, retry_o);
        end
`ifdef PACKET_RETRY_TX_STATS_EN
        checks++; if ({stat_sent_o, stat_retry_o, stat_fail_o} !== 48'd0) begin errors++; $display("FAIL mid_stats: got %0d %0d %0d want 0 0 0", stat_sent_o, stat_retry_o, stat_fail_o); end
`endif
        s_if.tvalid = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        pkt_q = '{8'hC1, 8'hC2, 8'hC3}; kind_q = '{K_ACK}; dly_q = '{2};
        drive_packet(0, 0);
        checks++;
        if (ob_data.size() !== 3 || ob_data[0] !== 8'hC1 || ob_next.size() !== 1 || ob_redo.size() !== 0) begin
            errors++; $display("FAIL mid_restart: got beats=%0d first=%h next=%0d redo=%0d want 3 c1 1 0", ob_data.size(), ob_data[0], ob_next.size(), ob_redo.size());
        end
`ifdef PACKET_RETRY_TX_STATS_EN
        checks++; if (stat_sent_o !== 16'd1 || stat_retry_o !== 16'd0 || stat_fail_o !== 16'd0) begin errors++; $display("FAIL mid_stats_after: got %0d %0d %0d want 1 0 0", stat_sent_o, stat_retry_o, stat_fail_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_ack();
        test_nak_then_ack();
        test_timeout_fail();
        test_backpressure();
        test_simultaneous();
        test_stray_ack();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
